// File: rtl/tz_rsp_tx.sv
// Read-response transmitter for a security-tagged register bank: tagged reads are
// resolved against per-register owners and queued into an in-order response FIFO.

module tz_reg_cell #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wns,
   output logic [DATA_W-1:0] data,
   output logic              ns
);
   // Owner resets to secure so nothing leaks before software assigns ownership.
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
         ns   <= 1'b0;
      end else if (we) begin
         data <= wdata;
         ns   <= wns;
      end
   end
endmodule

module tz_rsp_tx #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 4,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_security_level,
   input  logic              wr_mark_ns,
   output logic              wr_viol,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_security_level,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              rsp_security_level
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              err;
      logic              sec;
   } rsp_t;

   logic [NREGS-1:0][DATA_W-1:0] reg_data;
   logic [NREGS-1:0]             reg_ns;
   logic [NREGS-1:0]             reg_we;

   // Write path: out-of-range and non-secure-to-secure writes are dropped.
   logic wr_in_range, wr_hit_ns, wr_ok, wr_new_ns;

   always_comb begin
      wr_in_range = 1'b0;
      wr_hit_ns   = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (wr_addr == ADDR_W'(i)) begin
            wr_in_range = 1'b1;
            wr_hit_ns   = reg_ns[i];
         end
      end
   end

   assign wr_ok     = wr_en & wr_in_range & (~wr_security_level | wr_hit_ns);
   // A non-secure write only lands on a non-secure register, so its owner stays non-secure.
   assign wr_new_ns = wr_security_level ? 1'b1 : wr_mark_ns;

   genvar g;
   generate
      for (g = 0; g < NREGS; g++) begin : g_reg
         assign reg_we[g] = wr_ok & (wr_addr == ADDR_W'(g));
         tz_reg_cell #(.DATA_W(DATA_W)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .we    (reg_we[g]),
            .wdata (wr_data),
            .wns   (wr_new_ns),
            .data  (reg_data[g]),
            .ns    (reg_ns[g])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) wr_viol <= 1'b0;
      else     wr_viol <= wr_en & ~wr_ok;
   end

   // Read path samples pre-edge register state, giving read-before-write on collisions.
   logic              rd_in_range, rd_ns;
   logic [DATA_W-1:0] rd_data;
   rsp_t              push_ent;

   always_comb begin
      rd_in_range = 1'b0;
      rd_ns       = 1'b0;
      rd_data     = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (req_addr == ADDR_W'(i)) begin
            rd_in_range = 1'b1;
            rd_ns       = reg_ns[i];
            rd_data     = reg_data[i];
         end
      end
   end

   always_comb begin
      push_ent.err  = ~rd_in_range | (req_security_level & ~rd_ns);
      push_ent.data = push_ent.err ? '0 : rd_data;
      push_ent.sec  = req_security_level;
   end

   // Response FIFO
   rsp_t             fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             push, pop;
   rsp_t             head;

   assign req_ready = (count < DEPTH_C) & ~rst;
   assign rsp_valid = (count != '0);
   assign push      = req_valid & req_ready;
   assign pop       = rsp_valid & rsp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= push_ent;
   end

   assign head               = fifo_mem[rd_ptr];
   assign rsp_data           = rsp_valid ? head.data : '0;
   assign rsp_err            = rsp_valid & head.err;
   assign rsp_security_level = rsp_valid & head.sec;
endmodule

// File: doc/tz_rsp_tx.md
Name: tz_rsp_tx

Overview:
- Read-response transmitter for TrustZone-tagged peripheral traffic. It is the return path for the security-tagged write-data path.
- Holds a small register bank, each register with a secure/non-secure owner attribute.
- Accepts tagged read requests from the SoC and sends tagged responses back through a buffered valid/ready channel.
- Secure-owned contents never reach a non-secure requester.
- Security level encoding everywhere: 0 = secure, 1 = non-secure.

Parameters:
- DATA_W, 32, data width of registers and responses.
- NREGS, 4, number of registers; addresses 0..NREGS-1 are valid.
- ADDR_W, 3, request/write address width; must satisfy 2**ADDR_W > NREGS so out-of-range addresses are representable.
- DEPTH, 4, response FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_security_level  in  1  writer's level.
- wr_mark_ns  in  1  on a secure write, 1 hands ownership of the register to non-secure.
- wr_viol  out  1  one-cycle pulse when a write is dropped.
- req_valid  in  1  read request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  ADDR_W  read address.
- req_security_level  in  1  requester's level.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_data  out  DATA_W  response data.
- rsp_err  out  1  1 = access denied or address out of range.
- rsp_security_level  out  1  echo of the originating request's level.

Behaviour:
- Reset (rst=1 at an edge):
  - All register data cleared to 0; all owners set to secure (fail-safe).
  - FIFO emptied.
  - rsp_valid=0, rsp_data=0, rsp_err=0, rsp_security_level=0, wr_viol=0.
  - req_ready is 0 only while rst is asserted.
  - Reset mid-operation discards all queued responses with no partial output.
- Write rules, evaluated at the edge when wr_en=1:
  - wr_addr >= NREGS: dropped; wr_viol=1 next cycle.
  - Secure write (wr_security_level=0): data updated; owner set to non-secure if wr_mark_ns=1, else secure.
  - Non-secure write to a non-secure-owned register: data updated; owner unchanged; wr_mark_ns ignored.
  - Non-secure write to a secure-owned register: dropped; wr_viol=1 for exactly the following cycle.
- Request acceptance:
  - req_ready = (fifo_count < DEPTH) & !rst.
  - There is no same-cycle pass-through when full, even if a pop occurs that cycle.
- Response formation, at the acceptance edge:
  - Out-of-range address: data=0, err=1.
  - req_security_level=1 and the register is secure-owned: data=0, err=1.
  - Otherwise: data = register contents, err=0.
  - sec = req_security_level in every case.
  - The entry is pushed into the FIFO.
- Read/write collision on the same address in the same cycle: the read returns the pre-write data and pre-write owner (read-before-write).
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N (visible in cycle N+1) when the FIFO was empty; otherwise responses are strictly in order.
- Output channel:
  - rsp_* present the FIFO head.
  - While rsp_valid=0, rsp_data, rsp_err and rsp_security_level are driven 0.
  - While rsp_valid=1 and rsp_ready=0, all rsp_* hold stable.
- FIFO pointers: wrap modulo DEPTH; count is 0..DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when empty, or push when full, cannot occur by construction.

Test Plan:
1. Reset, then check: all outputs 0, req_ready=1. Non-secure read of addr 0 -> rsp_err=1, rsp_data=0, rsp_security_level=1 (owner secure after reset).
2. Secure write addr 1 = 0xDEADBEEF with wr_mark_ns=1. Then a non-secure read of addr 1 -> rsp_data=0xDEADBEEF, err=0, sec=1. Then a secure rewrite 0x12345678 with wr_mark_ns=0, then a non-secure read -> data=0, err=1.
3. Non-secure write to secure-owned addr 2 -> wr_viol high exactly one cycle; a following secure read returns the old value 0, err=0, sec=0.
4. Hold rsp_ready=0 and issue 5 requests -> 4 accepted, then req_ready=0 with rsp_* stable. Raise rsp_ready -> responses drain in order and req_ready returns 1 in the cycle after the first pop.
5. Same-cycle secure write 0xA5A5A5A5 and secure read of addr 3 (previously 0x1) -> response data 0x1. Read of addr 5 (out of range) -> err=1, data=0.
6. Assert rst with 3 responses queued -> next cycle rsp_valid=0, all register data 0, owners secure.
